// File: rtl/rv_pkg.sv
// Shared RV decode types: immediate format select
// and skid-buffer FSM state encodings.
package rv_pkg;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_U   = 3'b011,
    IMM_J   = 3'b100,
    IMM_Z   = 3'b101,
    IMM_SH  = 3'b110,
    IMM_RSV = 3'b111
  } imm_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } buf_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV immediate decoder.
// Ports: instruction/imm_op in; imm, illegal out.
module imm_decode
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction,
  input  imm_op_e         imm_op,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] w_i;
  logic [31:0] w_s;
  logic [31:0] w_b;
  logic [31:0] w_u;
  logic [31:0] w_j;
  logic [5:0]  w_sh;
  logic        w_unused;

  assign w_i = {{20{instruction[31]}},
                instruction[31:20]};
  assign w_s = {{20{instruction[31]}},
                instruction[31:25],
                instruction[11:7]};
  assign w_b = {{20{instruction[31]}},
                instruction[7],
                instruction[30:25],
                instruction[11:8],
                1'b0};
  assign w_u = {instruction[31:12], 12'b0};
  assign w_j = {{12{instruction[31]}},
                instruction[19:12],
                instruction[20],
                instruction[30:21],
                1'b0};

  // RV64 shamt is one bit wider.
  assign w_sh = (XLEN == 64) ?
                instruction[25:20] :
                {1'b0, instruction[24:20]};

  assign w_unused = ^instruction[6:0];

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    unique case (imm_op)
      IMM_I:   imm = XLEN'($signed(w_i));
      IMM_S:   imm = XLEN'($signed(w_s));
      IMM_B:   imm = XLEN'($signed(w_b));
      IMM_U:   imm = XLEN'($signed(w_u));
      IMM_J:   imm = XLEN'($signed(w_j));
      IMM_Z:   imm = XLEN'(instruction[19:15]);
      IMM_SH:  imm = XLEN'(w_sh);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_unit.sv
// Immediate unit: decode + 2-entry skid buffer
// + saturating illegal-format counter.
module imm_unit
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic [2:0]       imm_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  buf_state_e       r_state;
  logic [XLEN-1:0]  r_hd_imm;
  logic [TAG_W-1:0] r_hd_tag;
  logic             r_hd_ill;
  logic [XLEN-1:0]  r_tl_imm;
  logic [TAG_W-1:0] r_tl_tag;
  logic             r_tl_ill;
  logic [CNT_W-1:0] r_cnt;

  logic [XLEN-1:0]  w_imm;
  logic             w_ill;
  logic             w_acc;
  logic             w_drn;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instruction (instruction),
    .imm_op      (imm_op_e'(imm_op)),
    .imm         (w_imm),
    .illegal     (w_ill)
  );

  assign in_ready    = (r_state != ST_TWO);
  assign out_valid   = (r_state != ST_EMPTY);
  assign w_acc       = in_valid && in_ready;
  assign w_drn       = out_valid && out_ready;
  assign imm         = r_hd_imm;
  assign out_tag     = r_hd_tag;
  assign out_illegal = r_hd_ill;
  assign illegal_cnt = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_EMPTY;
      r_hd_imm <= '0;
      r_hd_tag <= '0;
      r_hd_ill <= 1'b0;
      r_tl_imm <= '0;
      r_tl_tag <= '0;
      r_tl_ill <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_acc && w_ill && (r_cnt != '1))
        r_cnt <= r_cnt + CNT_W'(1);
      unique case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_hd_imm <= w_imm;
            r_hd_tag <= in_tag;
            r_hd_ill <= w_ill;
            r_state  <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_acc && w_drn) begin
            r_hd_imm <= w_imm;
            r_hd_tag <= in_tag;
            r_hd_ill <= w_ill;
          end else if (w_acc) begin
            r_tl_imm <= w_imm;
            r_tl_tag <= in_tag;
            r_tl_ill <= w_ill;
            r_state  <= ST_TWO;
          end else if (w_drn) begin
            r_state  <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // Full: in_ready is low, only drain.
          if (w_drn) begin
            r_hd_imm <= r_tl_imm;
            r_hd_tag <= r_tl_tag;
            r_hd_ill <= r_tl_ill;
            r_state  <= ST_ONE;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_unit.sv
// Directed bench for imm_unit: XLEN=32, XLEN=64
// and CNT_W=2 instances checked against constants.
module tb_imm_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // XLEN=32 instance
  logic        a_rst, a_vld, a_ird, a_ovld, a_ord;
  logic [31:0] a_ins;
  logic [2:0]  a_op;
  logic [4:0]  a_tag, a_otag;
  logic [31:0] a_imm;
  logic        a_ill;
  logic [15:0] a_cnt;

  // XLEN=64 instance
  logic        b_rst, b_vld, b_ird, b_ovld, b_ord;
  logic [31:0] b_ins;
  logic [2:0]  b_op;
  logic [4:0]  b_tag, b_otag;
  logic [63:0] b_imm;
  logic        b_ill;
  logic [15:0] b_cnt;

  // CNT_W=2 instance
  logic        c_rst, c_vld, c_ird, c_ovld, c_ord;
  logic [31:0] c_ins;
  logic [2:0]  c_op;
  logic [4:0]  c_tag, c_otag;
  logic [31:0] c_imm;
  logic        c_ill;
  logic [1:0]  c_cnt;

  imm_unit #(.XLEN(32)) u_a (
    .clk(clk), .rst(a_rst),
    .in_valid(a_vld), .in_ready(a_ird),
    .instruction(a_ins), .imm_op(a_op),
    .in_tag(a_tag), .out_valid(a_ovld),
    .out_ready(a_ord), .imm(a_imm),
    .out_tag(a_otag), .out_illegal(a_ill),
    .illegal_cnt(a_cnt)
  );

  imm_unit #(.XLEN(64)) u_b (
    .clk(clk), .rst(b_rst),
    .in_valid(b_vld), .in_ready(b_ird),
    .instruction(b_ins), .imm_op(b_op),
    .in_tag(b_tag), .out_valid(b_ovld),
    .out_ready(b_ord), .imm(b_imm),
    .out_tag(b_otag), .out_illegal(b_ill),
    .illegal_cnt(b_cnt)
  );

  imm_unit #(.XLEN(32), .CNT_W(2)) u_c (
    .clk(clk), .rst(c_rst),
    .in_valid(c_vld), .in_ready(c_ird),
    .instruction(c_ins), .imm_op(c_op),
    .in_tag(c_tag), .out_valid(c_ovld),
    .out_ready(c_ord), .imm(c_imm),
    .out_tag(c_otag), .out_illegal(c_ill),
    .illegal_cnt(c_cnt)
  );

  task automatic push_a(input logic [2:0] op,
                        input logic [31:0] ins,
                        input logic [4:0] tag);
    @(negedge clk);
    a_vld = 1'b1; a_op = op;
    a_ins = ins;  a_tag = tag;
    @(posedge clk); #1;
    a_vld = 1'b0;
  endtask

  task automatic push_b(input logic [2:0] op,
                        input logic [31:0] ins,
                        input logic [4:0] tag);
    @(negedge clk);
    b_vld = 1'b1; b_op = op;
    b_ins = ins;  b_tag = tag;
    @(posedge clk); #1;
    b_vld = 1'b0;
  endtask

  task automatic push_c(input logic [2:0] op,
                        input logic [31:0] ins,
                        input logic [4:0] tag);
    @(negedge clk);
    c_vld = 1'b1; c_op = op;
    c_ins = ins;  c_tag = tag;
    @(posedge clk); #1;
    c_vld = 1'b0;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_vld = 1'b0; b_vld = 1'b0; c_vld = 1'b0;
    a_ord = 1'b1; b_ord = 1'b1; c_ord = 1'b1;
    a_ins = '0; b_ins = '0; c_ins = '0;
    a_op = '0; b_op = '0; c_op = '0;
    a_tag = '0; b_tag = '0; c_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (a_ovld !== 1'b0 || a_ird !== 1'b1) begin
      n_err++;
      $display("FAIL reset_hs32: ovld=%b ird=%b want 0 1",
               a_ovld, a_ird);
    end
    n_vec++;
    if (a_imm !== 32'h0 || a_otag !== 5'h0 ||
        a_ill !== 1'b0 || a_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL reset_out32: imm=%h tag=%h ill=%b cnt=%h want 0",
               a_imm, a_otag, a_ill, a_cnt);
    end
    n_vec++;
    if (b_ovld !== 1'b0 || b_ird !== 1'b1 ||
        b_imm !== 64'h0 || b_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL reset_64: ovld=%b ird=%b imm=%h cnt=%h",
               b_ovld, b_ird, b_imm, b_cnt);
    end
  endtask

  task automatic test_formats32();
    push_a(3'b000, 32'hFFF00093, 5'd7);
    n_vec++;
    if (a_ovld !== 1'b1 || a_imm !== 32'hFFFFFFFF ||
        a_otag !== 5'd7 || a_ill !== 1'b0) begin
      n_err++;
      $display("FAIL fmt_I: v=%b imm=%h tag=%0d want 1 FFFFFFFF 7",
               a_ovld, a_imm, a_otag);
    end
    push_a(3'b010, 32'hFE000EE3, 5'd8);
    n_vec++;
    if (a_imm !== 32'hFFFFFFFC || a_otag !== 5'd8) begin
      n_err++;
      $display("FAIL fmt_B: imm=%h tag=%0d want FFFFFFFC 8",
               a_imm, a_otag);
    end
    push_a(3'b001, 32'hFE000FA3, 5'd9);
    n_vec++;
    if (a_imm !== 32'hFFFFFFFF) begin
      n_err++;
      $display("FAIL fmt_S: imm=%h want FFFFFFFF", a_imm);
    end
    push_a(3'b100, 32'hFFDFF06F, 5'd10);
    n_vec++;
    if (a_imm !== 32'hFFFFFFFC) begin
      n_err++;
      $display("FAIL fmt_J: imm=%h want FFFFFFFC", a_imm);
    end
    push_a(3'b101, 32'h000F8073, 5'd11);
    n_vec++;
    if (a_imm !== 32'h0000001F || a_ill !== 1'b0) begin
      n_err++;
      $display("FAIL fmt_Z: imm=%h ill=%b want 1F 0",
               a_imm, a_ill);
    end
    push_a(3'b110, 32'h03F01013, 5'd12);
    n_vec++;
    if (a_imm !== 32'h0000001F) begin
      n_err++;
      $display("FAIL fmt_SH32: imm=%h want 1F", a_imm);
    end
    @(posedge clk); #1;
    n_vec++;
    if (a_ovld !== 1'b0) begin
      n_err++;
      $display("FAIL drain_empty: ovld=%b want 0", a_ovld);
    end
  endtask

  task automatic test_formats64();
    push_b(3'b011, 32'h80000537, 5'd3);
    n_vec++;
    if (b_ovld !== 1'b1 ||
        b_imm !== 64'hFFFFFFFF80000000 || b_otag !== 5'd3) begin
      n_err++;
      $display("FAIL fmt_U64: imm=%h tag=%0d want FFFFFFFF80000000 3",
               b_imm, b_otag);
    end
    push_b(3'b110, 32'h03F01013, 5'd4);
    n_vec++;
    if (b_imm !== 64'h3F) begin
      n_err++;
      $display("FAIL fmt_SH64: imm=%h want 3F", b_imm);
    end
    push_b(3'b000, 32'hFFF00093, 5'd5);
    n_vec++;
    if (b_imm !== 64'hFFFFFFFFFFFFFFFF) begin
      n_err++;
      $display("FAIL fmt_I64: imm=%h want all ones", b_imm);
    end
  endtask

  task automatic test_illegal();
    n_vec++;
    if (a_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL ill_cnt_pre: cnt=%0d want 0", a_cnt);
    end
    push_a(3'b111, 32'hFFFFFFFF, 5'd13);
    n_vec++;
    if (a_imm !== 32'h0 || a_ill !== 1'b1 ||
        a_otag !== 5'd13) begin
      n_err++;
      $display("FAIL ill_out: imm=%h ill=%b tag=%0d want 0 1 13",
               a_imm, a_ill, a_otag);
    end
    n_vec++;
    if (a_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL ill_cnt: cnt=%0d want 1", a_cnt);
    end
    @(posedge clk); #1;
    n_vec++;
    if (a_cnt !== 16'd1 || a_ovld !== 1'b0) begin
      n_err++;
      $display("FAIL ill_drain: cnt=%0d ovld=%b want 1 0",
               a_cnt, a_ovld);
    end
  endtask

  task automatic test_back_to_back();
    a_ord = 1'b0;
    for (int t = 1; t <= 2; t++) begin
      @(negedge clk);
      n_vec++;
      if (a_ird !== 1'b1) begin
        n_err++;
        $display("FAIL bp_ready%0d: ird=%b want 1", t, a_ird);
      end
      a_vld = 1'b1; a_op = 3'b000;
      a_ins = 32'(t) << 20; a_tag = 5'(t);
      @(posedge clk); #1;
    end
    a_ins = 32'd3 << 20; a_tag = 5'd3;
    n_vec++;
    if (a_ird !== 1'b0) begin
      n_err++;
      $display("FAIL bp_full: ird=%b want 0", a_ird);
    end
    repeat (2) begin
      @(posedge clk); #1;
      n_vec++;
      if (a_ovld !== 1'b1 || a_otag !== 5'd1 ||
          a_imm !== 32'd1 || a_ird !== 1'b0) begin
        n_err++;
        $display("FAIL bp_stall: v=%b tag=%0d imm=%h ird=%b want 1 1 1 0",
                 a_ovld, a_otag, a_imm, a_ird);
      end
    end
    @(negedge clk);
    a_ord = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (a_otag !== 5'd2 || a_imm !== 32'd2 ||
        a_ird !== 1'b1) begin
      n_err++;
      $display("FAIL bp_out2: tag=%0d imm=%h ird=%b want 2 2 1",
               a_otag, a_imm, a_ird);
    end
    @(posedge clk); #1;
    a_vld = 1'b0;
    n_vec++;
    if (a_ovld !== 1'b1 || a_otag !== 5'd3 ||
        a_imm !== 32'd3) begin
      n_err++;
      $display("FAIL bp_out3: v=%b tag=%0d imm=%h want 1 3 3",
               a_ovld, a_otag, a_imm);
    end
    @(posedge clk); #1;
    n_vec++;
    if (a_ovld !== 1'b0) begin
      n_err++;
      $display("FAIL bp_empty: ovld=%b want 0", a_ovld);
    end
  endtask

  task automatic test_saturate();
    for (int k = 1; k <= 5; k++) begin
      push_c(3'b111, 32'h0, 5'(k));
      n_vec++;
      if (c_cnt !== ((k < 3) ? 2'(k) : 2'd3)) begin
        n_err++;
        $display("FAIL sat_cnt%0d: cnt=%0d want %0d",
                 k, c_cnt, (k < 3) ? k : 3);
      end
    end
    @(posedge clk); #1;
    n_vec++;
    if (c_cnt !== 2'd3 || c_ovld !== 1'b0) begin
      n_err++;
      $display("FAIL sat_final: cnt=%0d ovld=%b want 3 0",
               c_cnt, c_ovld);
    end
  endtask

  task automatic test_reset_full();
    a_ord = 1'b0;
    push_a(3'b111, 32'h0, 5'd20);
    push_a(3'b000, 32'h00100000, 5'd21);
    n_vec++;
    if (a_ird !== 1'b0 || a_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL rstf_pre: ird=%b cnt=%0d want 0 2",
               a_ird, a_cnt);
    end
    @(negedge clk);
    a_rst = 1'b1;
    a_vld = 1'b1; a_op = 3'b111; a_tag = 5'd22;
    @(posedge clk); #1;
    n_vec++;
    if (a_ovld !== 1'b0 || a_ird !== 1'b1 ||
        a_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL rstf_post: ovld=%b ird=%b cnt=%0d want 0 1 0",
               a_ovld, a_ird, a_cnt);
    end
    @(negedge clk);
    a_rst = 1'b0; a_vld = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (a_ovld !== 1'b0 || a_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL rstf_idle: ovld=%b cnt=%0d want 0 0",
               a_ovld, a_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_formats32();
    test_formats64();
    test_illegal();
    test_back_to_back();
    test_saturate();
    test_reset_full();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
